bp_me_nonsynth_tr_replay_driver: RTL and testbench

//  Trace-replay driver for the CCE/mock-LCE testbench.
//  - Walks a trace ROM and drives load/store trace packets into the mock LCE's tr_pkt input port.
//  - Consumes the LCE's tr_pkt responses and checks each one against the expected value stored in the ROM.
//  - Reports done, error and a mismatch count to the top-level harness.

---
 rtl/bp_me_nonsynth_tr_replay_driver.sv | 163 ++++++++++++++++
 tb/tb_bp_me_nonsynth_tr_replay_driver.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_nonsynth_tr_replay_driver.sv
// Trace-replay driver for the CCE/mock-LCE testbench.
// Walks a trace ROM, drives SEND payloads to the mock LCE, checks RECV
// responses against ROM payloads, and reports done/error/mismatch count.
// Optional handshake watchdog: define BP_TR_REPLAY_WATCHDOG_EN.
module bp_me_nonsynth_tr_replay_driver #(
    parameter int tr_ring_width_p  = 109,
    parameter int rom_addr_width_p = 20,
    parameter int timeout_cycles_p = 4096
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          en_i,
    output logic [rom_addr_width_p-1:0]   rom_addr_o,
    input  logic [4+tr_ring_width_p-1:0]  rom_data_i,
    output logic                          tr_pkt_v_o,
    output logic [tr_ring_width_p-1:0]    tr_pkt_o,
    input  logic                          tr_pkt_yumi_i,
    input  logic                          tr_pkt_v_i,
    input  logic [tr_ring_width_p-1:0]    tr_pkt_i,
    output logic                          tr_pkt_ready_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [15:0]                   mismatch_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_DONE} state_e;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SEND = 4'd1;
    localparam logic [3:0] OP_RECV = 4'd2;
    localparam logic [3:0] OP_WAIT = 4'd3;
    localparam logic [3:0] OP_DONE = 4'd4;

    localparam logic [rom_addr_width_p-1:0] addr_one = 1;

    state_e                        state_q, state_d;
    logic [rom_addr_width_p-1:0]   addr_q, addr_d;
    logic                          err_q, err_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic [31:0]                   wait_q, wait_d;

    logic [3:0]                    op;
    logic [tr_ring_width_p-1:0]    payload;
    logic                          overrun;
    logic                          send_active;
    logic                          recv_active;
    logic                          stall;

    assign op      = rom_data_i[4+tr_ring_width_p-1 -: 4];
    assign payload = rom_data_i[tr_ring_width_p-1:0];

    // The last ROM slot may only hold DONE; anything else would need the
    // address to wrap, which is treated as a broken trace instead.
    assign overrun     = (&addr_q) && (op != OP_DONE);
    assign send_active = (state_q == S_EXEC) && !overrun && (op == OP_SEND);
    assign recv_active = (state_q == S_EXEC) && !overrun && (op == OP_RECV);
    assign stall       = (send_active && !tr_pkt_yumi_i) || (recv_active && !tr_pkt_v_i);

    // Handshake outputs depend only on state and ROM op, never on the peer's
    // valid/yumi, so no combinational loop can form through the LCE.
    assign tr_pkt_v_o     = send_active;
    assign tr_pkt_ready_o = recv_active;
    assign tr_pkt_o       = payload;
    assign rom_addr_o     = addr_q;
    assign done_o         = (state_q == S_DONE);
    assign error_o        = err_q;
    assign mismatch_cnt_o = cnt_q;

`ifdef BP_TR_REPLAY_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    logic        wd_expire;

    // A completed handshake or a new op both drop the stall, which clears the count.
    assign wd_d      = stall ? (wd_q + 32'd1) : 32'd0;
    assign wd_expire = stall && (wd_q == 32'(timeout_cycles_p - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |timeout_cycles_p;
`endif

    // Next-state logic: op decode, address advance, compare and wait countdown.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: if (en_i) state_d = S_EXEC;
            S_EXEC: begin
                if (overrun) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    case (op)
                        OP_NOP:  addr_d = addr_q + addr_one;
                        OP_SEND: if (tr_pkt_yumi_i) addr_d = addr_q + addr_one;
                        OP_RECV: begin
                            if (tr_pkt_v_i) begin
                                addr_d = addr_q + addr_one;
                                if (tr_pkt_i != payload) begin
                                    err_d = 1'b1;
                                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                                end
                            end
                        end
                        OP_WAIT: begin
                            wait_d  = payload[31:0];
                            state_d = S_WAIT;
                        end
                        OP_DONE: state_d = S_DONE;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                if (wait_q == 32'd0) begin
                    addr_d  = addr_q + addr_one;
                    state_d = S_EXEC;
                end else begin
                    wait_d = wait_q - 32'd1;
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
`ifdef BP_TR_REPLAY_WATCHDOG_EN
        if (wd_expire) begin
            err_d   = 1'b1;
            state_d = S_DONE;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= '0;
`ifdef BP_TR_REPLAY_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
`ifdef BP_TR_REPLAY_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

endmodule

// File: tb/tb_bp_me_nonsynth_tr_replay_driver.sv
// Self-checking bench for bp_me_nonsynth_tr_replay_driver: directed traces
// plus randomized traces scored against a trace-level model of the replay.
module tb_bp_me_nonsynth_tr_replay_driver;

    localparam int W  = 109;
    localparam int AW = 6;
    localparam int TO = 16;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic           en_i;
    logic [AW-1:0]  rom_addr_o;
    logic [W+3:0]   rom_data_i;
    logic           tr_pkt_v_o;
    logic [W-1:0]   tr_pkt_o;
    logic           tr_pkt_yumi_i;
    logic           tr_pkt_v_i;
    logic [W-1:0]   tr_pkt_i;
    logic           tr_pkt_ready_o;
    logic           done_o;
    logic           error_o;
    logic [15:0]    mismatch_cnt_o;

    logic [W+3:0]   rom [64];
    assign rom_data_i = rom[rom_addr_o];

    bp_me_nonsynth_tr_replay_driver #(
        .tr_ring_width_p (W),
        .rom_addr_width_p(AW),
        .timeout_cycles_p(TO)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .en_i          (en_i),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .tr_pkt_v_o    (tr_pkt_v_o),
        .tr_pkt_o      (tr_pkt_o),
        .tr_pkt_yumi_i (tr_pkt_yumi_i),
        .tr_pkt_v_i    (tr_pkt_v_i),
        .tr_pkt_i      (tr_pkt_i),
        .tr_pkt_ready_o(tr_pkt_ready_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .mismatch_cnt_o(mismatch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;

    // Mock LCE state
    logic [W-1:0] sent_q[$];
    logic [W-1:0] resp_q[$];
    int           yumi_delay;
    int           yumi_cnt;
    int           resp_delay;
    int           resp_wait;
    bit           saw_vr;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+3:0] ent(input logic [3:0] op, input logic [W-1:0] p);
        return {op, p};
    endfunction

    function automatic logic [W-1:0] rand_payload();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic fill_rom(input logic [3:0] op);
        for (int i = 0; i < 64; i++) rom[i] = ent(op, rand_payload());
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        en_i = 1'b0;
        tr_pkt_yumi_i = 1'b0;
        tr_pkt_v_i = 1'b0;
        tr_pkt_i = '0;
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    // One LCE cycle: decide yumi/response at the negedge, then advance one clock.
    task automatic lce_step();
        tr_pkt_yumi_i = 1'b0;
        if (tr_pkt_v_o) begin
            if (yumi_cnt >= yumi_delay) begin
                tr_pkt_yumi_i = 1'b1;
                sent_q.push_back(tr_pkt_o);
                yumi_cnt = 0;
            end else begin
                yumi_cnt++;
            end
        end
        tr_pkt_v_i = 1'b0;
        tr_pkt_i = '0;
        if (resp_q.size() != 0) begin
            if (resp_wait > 0) begin
                resp_wait--;
            end else begin
                tr_pkt_v_i = 1'b1;
                tr_pkt_i = resp_q[0];
                if (tr_pkt_ready_o) begin
                    void'(resp_q.pop_front());
                    resp_wait = resp_delay;
                end
            end
        end
        if (tr_pkt_v_o || tr_pkt_ready_o) saw_vr = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
    endtask

    // Start replay and step until done_o or the budget runs out; cycles counts from EXEC entry.
    task automatic run(input int budget, output int cycles);
        sent_q.delete();
        saw_vr = 1'b0;
        yumi_cnt = 0;
        en_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        en_i = 1'b0;
        cycles = 0;
        while (!done_o && cycles < budget) begin
            lce_step();
            cycles++;
        end
        check("run_reached_done", 128'(done_o), 128'(1));
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    initial begin
        int           cyc;
        int           exp_cyc;
        int           len;
        int           exp_mis;
        logic [W-1:0] exp_sent[$];
        logic [W-1:0] p;
        logic [W-1:0] one;
        one = 1;

        // Reset state
        fill_rom(OP_DONE_C());
        do_reset();
        check("rst_v", 128'(tr_pkt_v_o), 128'(0));
        check("rst_ready", 128'(tr_pkt_ready_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_error", 128'(error_o), 128'(0));
        check("rst_cnt", 128'(mismatch_cnt_o), 128'(0));
        check("rst_addr", 128'(rom_addr_o), 128'(0));

        // en_i ignored once DONE is reached: address stays put
        // 1. SEND A, RECV A, DONE; echo after 3 cycles, yumi immediate
        fill_rom(OP_DONE_C());
        p = rand_payload();
        rom[0] = ent(4'd1, p);
        rom[1] = ent(4'd2, p);
        do_reset();
        resp_q.delete(); resp_q.push_back(p);
        yumi_delay = 0; resp_delay = 3; resp_wait = 3;
        run(200, cyc);
        check("t1_error", 128'(error_o), 128'(0));
        check("t1_cnt", 128'(mismatch_cnt_o), 128'(0));
        check("t1_sent_n", 128'(sent_q.size()), 128'(1));
        if (sent_q.size() == 1) check("t1_sent", 128'(sent_q[0]), 128'(p));
        check("t1_addr", 128'(rom_addr_o), 128'(2));
        en_i = 1'b1; lce_step(); lce_step(); en_i = 1'b0;
        check("t1_done_sticky", 128'(done_o), 128'(1));
        check("t1_addr_hold", 128'(rom_addr_o), 128'(2));

        // 2. RECV expects 5, LCE returns 7; next SEND still executes
        fill_rom(OP_DONE_C());
        p = rand_payload();
        rom[0] = ent(4'd2, W'(5));
        rom[1] = ent(4'd1, p);
        do_reset();
        resp_q.delete(); resp_q.push_back(W'(7));
        yumi_delay = 0; resp_delay = 0; resp_wait = 0;
        run(200, cyc);
        check("t2_cnt", 128'(mismatch_cnt_o), 128'(1));
        check("t2_error", 128'(error_o), 128'(1));
        check("t2_sent_n", 128'(sent_q.size()), 128'(1));
        if (sent_q.size() == 1) check("t2_sent", 128'(sent_q[0]), 128'(p));

        // 3. SEND with yumi held low for 10 cycles
        fill_rom(OP_DONE_C());
        p = rand_payload();
        rom[0] = ent(4'd1, p);
        do_reset();
        en_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t3_v_held", 128'(tr_pkt_v_o), 128'(1));
            check("t3_pkt_stable", 128'(tr_pkt_o), 128'(p));
            check("t3_addr_held", 128'(rom_addr_o), 128'(0));
            @(posedge clk_i); @(negedge clk_i);
        end
        tr_pkt_yumi_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        tr_pkt_yumi_i = 1'b0;
        check("t3_addr_adv", 128'(rom_addr_o), 128'(1));
        check("t3_v_drop", 128'(tr_pkt_v_o), 128'(0));

        // 4. WAIT 0, WAIT 5, DONE: 2 + 7 + 1 cycles from EXEC entry
        fill_rom(OP_DONE_C());
        rom[0] = ent(4'd3, W'(0));
        rom[1] = ent(4'd3, W'(5));
        do_reset();
        resp_q.delete(); yumi_delay = 0;
        run(200, cyc);
        check("t4_cycles", 128'(cyc), 128'(10));
        check("t4_no_vr", 128'(saw_vr), 128'(0));
        check("t4_error", 128'(error_o), 128'(0));

        // Random NOP/WAIT timing traces: each NOP costs 1, WAIT n costs n+2, DONE costs 1
        for (int it = 0; it < 3; it++) begin
            fill_rom(OP_DONE_C());
            len = $urandom_range(3, 15);
            exp_cyc = 1;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    rom[i] = ent(4'd0, rand_payload());
                    exp_cyc += 1;
                end else begin
                    p = rand_payload();
                    p[31:0] = 32'($urandom_range(0, 6));
                    rom[i] = ent(4'd3, p);
                    exp_cyc += int'(p[31:0]) + 2;
                end
            end
            do_reset();
            resp_q.delete();
            run(500, cyc);
            check("rt_cycles", 128'(cyc), 128'(exp_cyc));
            check("rt_addr", 128'(rom_addr_o), 128'(len));
            check("rt_no_vr", 128'(saw_vr), 128'(0));
        end

        // Random mixed traces against the trace-level scoreboard
        for (int it = 0; it < 4; it++) begin
            fill_rom(OP_DONE_C());
            len = $urandom_range(6, 20);
            exp_sent.delete(); resp_q.delete(); exp_mis = 0;
            for (int i = 0; i < len; i++) begin
                p = rand_payload();
                case ($urandom_range(0, 3))
                    0: rom[i] = ent(4'd0, p);
                    1: begin rom[i] = ent(4'd1, p); exp_sent.push_back(p); end
                    2: begin
                        rom[i] = ent(4'd2, p);
                        if ($urandom_range(0, 2) == 0) begin
                            resp_q.push_back(p ^ (one << $urandom_range(0, W-1)));
                            exp_mis++;
                        end else begin
                            resp_q.push_back(p);
                        end
                    end
                    default: begin
                        p[31:0] = 32'($urandom_range(0, 4));
                        rom[i] = ent(4'd3, p);
                    end
                endcase
            end
            do_reset();
            yumi_delay = $urandom_range(0, 3);
            resp_delay = $urandom_range(0, 4);
            resp_wait = resp_delay;
            run(3000, cyc);
            check("mx_cnt", 128'(mismatch_cnt_o), 128'(exp_mis));
            check("mx_error", 128'(error_o), 128'(exp_mis != 0));
            check("mx_addr", 128'(rom_addr_o), 128'(len));
            check("mx_resp_left", 128'(resp_q.size()), 128'(0));
            check("mx_sent_n", 128'(sent_q.size()), 128'(exp_sent.size()));
            for (int i = 0; i < exp_sent.size() && i < sent_q.size(); i++)
                check("mx_sent", 128'(sent_q[i]), 128'(exp_sent[i]));
        end

        // 5. Illegal op 0xA at addr 2
        fill_rom(OP_DONE_C());
        rom[0] = ent(4'd0, rand_payload());
        rom[1] = ent(4'd0, rand_payload());
        rom[2] = ent(4'hA, rand_payload());
        do_reset();
        run(100, cyc);
        check("t5_cycles", 128'(cyc), 128'(3));
        check("t5_error", 128'(error_o), 128'(1));
        lce_step(); lce_step();
        check("t5_addr", 128'(rom_addr_o), 128'(2));

        // Address overrun: all-NOP ROM stops at the last slot without wrapping
        fill_rom(4'd0);
        do_reset();
        run(200, cyc);
        check("ovr_cycles", 128'(cyc), 128'(64));
        check("ovr_error", 128'(error_o), 128'(1));
        check("ovr_addr", 128'(rom_addr_o), 128'(63));

        // 6. Reset mid-SEND with yumi never given
        fill_rom(OP_DONE_C());
        rom[0] = ent(4'd1, rand_payload());
        do_reset();
        en_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        en_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        @(posedge clk_i); @(negedge clk_i);
        check("t6_v_before", 128'(tr_pkt_v_o), 128'(1));
        reset_n_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check("t6_v", 128'(tr_pkt_v_o), 128'(0));
        check("t6_ready", 128'(tr_pkt_ready_o), 128'(0));
        check("t6_done", 128'(done_o), 128'(0));
        check("t6_error", 128'(error_o), 128'(0));
        check("t6_addr", 128'(rom_addr_o), 128'(0));
        reset_n_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        check("t6_idle_v", 128'(tr_pkt_v_o), 128'(0));
`ifdef BP_TR_REPLAY_WATCHDOG_EN
        resp_q.delete();
        yumi_delay = 1000000;
        run(200, cyc);
        check("t6_wd_cycles", 128'(cyc), 128'(TO));
        check("t6_wd_error", 128'(error_o), 128'(1));
        check("t6_wd_sent", 128'(sent_q.size()), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    function automatic logic [3:0] OP_DONE_C();
        return 4'd4;
    endfunction

endmodule
